// File: rtl/matrix_rf_pkg.sv
// Shared encodings and lane-index helper for matrix_register_bank.
package matrix_rf_pkg;

    typedef enum logic [1:0] {
        CELL = 2'b00,
        ROW  = 2'b01,
        COL  = 2'b10,
        DIAG = 2'b11
    } acc_type_e;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Cell index (row*size + col) that lane 'lane' touches for an access.
    function automatic int lane_index(input acc_type_e typ, input int addr,
                                      input int lane, input int size);
        case (typ)
            CELL:    return addr;
            ROW:     return addr + lane;
            COL:     return addr + lane * size;
            default: return lane * (size + 1);
        endcase
    endfunction

endpackage

// File: rtl/matrix_rf_addr_check.sv
// Combinational legality check and per-lane cell indices, shared by the
// read and write paths of matrix_register_bank.
module matrix_rf_addr_check
    import matrix_rf_pkg::*;
#(
    parameter int SIZE         = 4,
    parameter int NUM_MATRICES = 3,
    parameter int ADDR_WIDTH   = $clog2(SIZE * SIZE),
    parameter int SEL_WIDTH    = (NUM_MATRICES > 1) ? $clog2(NUM_MATRICES) : 1
) (
    input  logic [1:0]                       i_type,
    input  logic [ADDR_WIDTH-1:0]            i_addr,
    input  logic [SEL_WIDTH-1:0]             i_sel,
    output logic                             o_legal,
    output logic [SIZE-1:0][ADDR_WIDTH-1:0]  o_idx
);

    logic w_sel_ok;
    logic w_addr_ok;
    int   w_addr;

    assign w_addr   = int'(i_addr);
    assign w_sel_ok = int'(i_sel) < NUM_MATRICES;

    always_comb begin
        w_addr_ok = 1'b0;
        case (acc_type_e'(i_type))
            CELL:    w_addr_ok = w_addr < SIZE * SIZE;
            ROW:     w_addr_ok = (w_addr < SIZE * SIZE) && (w_addr % SIZE == 0);
            COL:     w_addr_ok = w_addr < SIZE;
            default: w_addr_ok = w_addr == 0;
        endcase
    end

    assign o_legal = w_sel_ok & w_addr_ok;

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < SIZE; i++)
            o_idx[i] = ADDR_WIDTH'(lane_index(acc_type_e'(i_type), w_addr, i, SIZE));
    end

endmodule

// File: rtl/matrix_register_bank.sv
// Multi-matrix register store with cell/row/column/diagonal access and a
// sequenced row-by-row clear. Define MATRIX_RF_BYPASS_EN to return write data
// on read+write requests instead of pre-write contents.
module matrix_register_bank
    import matrix_rf_pkg::*;
#(
    parameter int SIZE         = 4,
    parameter int CELL_WIDTH   = 32,
    parameter int NUM_MATRICES = 3,
    parameter int ADDR_WIDTH   = $clog2(SIZE * SIZE),
    parameter int SEL_WIDTH    = (NUM_MATRICES > 1) ? $clog2(NUM_MATRICES) : 1
) (
    input  logic                         in_clk,
    input  logic                         in_reset,
    input  logic                         in_req_valid,
    output logic                         out_req_ready,
    input  logic                         in_read_en,
    input  logic                         in_write_en,
    input  logic [1:0]                   in_type,
    input  logic [SEL_WIDTH-1:0]         in_select_matrix,
    input  logic [ADDR_WIDTH-1:0]        in_address,
    input  logic [SIZE*CELL_WIDTH-1:0]   in_data,
    input  logic                         in_clear,
    output logic [SIZE*CELL_WIDTH-1:0]   out_data,
    output logic                         out_rd_valid,
    output logic                         out_error,
    output logic                         out_busy
);

    localparam int SS    = SIZE * SIZE;
    localparam int TOTAL = NUM_MATRICES * SS;
    localparam int MW    = $clog2(TOTAL);
    localparam int RW    = $clog2(SIZE);

    logic [CELL_WIDTH-1:0]           r_mem [TOTAL];
    logic [SIZE*CELL_WIDTH-1:0]      r_data;
    logic                            r_rd_valid;
    logic                            r_error;
    state_e                          r_state;
    state_e                          w_state_nxt;
    logic [RW-1:0]                   r_row;
    logic [SEL_WIDTH-1:0]            r_clr_mat;

    logic                            w_busy;
    logic                            w_accept;
    logic                            w_legal;
    logic                            w_clr_sel_ok;
    logic                            w_clr_start;
    logic [SIZE-1:0][ADDR_WIDTH-1:0] w_idx;
    logic [SIZE-1:0][MW-1:0]         w_flat;
    logic [SIZE*CELL_WIDTH-1:0]      w_rd_next;

    matrix_rf_addr_check #(
        .SIZE         (SIZE),
        .NUM_MATRICES (NUM_MATRICES),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .SEL_WIDTH    (SEL_WIDTH)
    ) u_addr_check (
        .i_type  (in_type),
        .i_addr  (in_address),
        .i_sel   (in_select_matrix),
        .o_legal (w_legal),
        .o_idx   (w_idx)
    );

    assign out_req_ready = ~w_busy & ~in_clear;
    assign w_accept      = in_req_valid & out_req_ready;
    assign w_clr_sel_ok  = int'(in_select_matrix) < NUM_MATRICES;
    assign w_clr_start   = in_clear & ~w_busy & w_clr_sel_ok;

    // Illegal requests fold to index 0 so no lane ever addresses past the array.
    always_comb begin
        w_flat = '0;
        for (int i = 0; i < SIZE; i++)
            if (w_legal)
                w_flat[i] = MW'(int'(in_select_matrix) * SS + int'(w_idx[i]));
    end

    always_comb begin
        w_rd_next = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (in_type != CELL || i == 0) begin
`ifdef MATRIX_RF_BYPASS_EN
                w_rd_next[i*CELL_WIDTH +: CELL_WIDTH] = in_write_en ?
                    in_data[i*CELL_WIDTH +: CELL_WIDTH] : r_mem[w_flat[i]];
`else
                w_rd_next[i*CELL_WIDTH +: CELL_WIDTH] = r_mem[w_flat[i]];
`endif
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_clr_start) w_state_nxt = CLEAR;
            default: if (r_row == RW'(SIZE - 1)) w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == CLEAR);
    end

    assign out_busy = w_busy;

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_row     <= '0;
            r_clr_mat <= '0;
        end else if (w_busy) begin
            r_row <= r_row + RW'(1);
        end else begin
            r_row <= '0;
            if (w_clr_start) r_clr_mat <= in_select_matrix;
        end
    end

    // Requests and the clear never overlap: ready is low throughout CLEAR.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            for (int k = 0; k < TOTAL; k++) r_mem[MW'(k)] <= '0;
        end else if (w_busy) begin
            for (int c = 0; c < SIZE; c++)
                r_mem[MW'(int'(r_clr_mat) * SS + int'(r_row) * SIZE + c)] <= '0;
        end else if (w_accept && in_write_en && w_legal) begin
            for (int i = 0; i < SIZE; i++)
                if (in_type != CELL || i == 0)
                    r_mem[w_flat[i]] <= in_data[i*CELL_WIDTH +: CELL_WIDTH];
        end
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_data     <= '0;
            r_rd_valid <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_rd_valid <= w_accept & in_read_en & w_legal;
            r_error    <= (w_accept & (in_read_en | in_write_en) & ~w_legal) |
                          (in_clear & ~w_busy & ~w_clr_sel_ok);
            if (w_accept && in_read_en && w_legal) r_data <= w_rd_next;
        end
    end

    assign out_data     = r_data;
    assign out_rd_valid = r_rd_valid;
    assign out_error    = r_error;

endmodule

// File: tb/tb_matrix_register_bank.sv
// Directed table-driven bench for matrix_register_bank (SIZE=4, 32-bit, 3 matrices).
module tb_matrix_register_bank;

    logic         in_clk = 1'b0;
    logic         in_reset = 1'b0;
    logic         in_req_valid = 1'b0;
    logic         out_req_ready;
    logic         in_read_en = 1'b0;
    logic         in_write_en = 1'b0;
    logic [1:0]   in_type = 2'b00;
    logic [1:0]   in_select_matrix = 2'b00;
    logic [3:0]   in_address = 4'd0;
    logic [127:0] in_data = '0;
    logic         in_clear = 1'b0;
    logic [127:0] out_data;
    logic         out_rd_valid;
    logic         out_error;
    logic         out_busy;

    int n_cmp = 0;
    int n_bad = 0;

    matrix_register_bank #(
        .SIZE(4), .CELL_WIDTH(32), .NUM_MATRICES(3)
    ) dut (
        .in_clk           (in_clk),
        .in_reset         (in_reset),
        .in_req_valid     (in_req_valid),
        .out_req_ready    (out_req_ready),
        .in_read_en       (in_read_en),
        .in_write_en      (in_write_en),
        .in_type          (in_type),
        .in_select_matrix (in_select_matrix),
        .in_address       (in_address),
        .in_data          (in_data),
        .in_clear         (in_clear),
        .out_data         (out_data),
        .out_rd_valid     (out_rd_valid),
        .out_error        (out_error),
        .out_busy         (out_busy)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        string        name;
        logic         rd;
        logic         wr;
        logic [1:0]   typ;
        logic [1:0]   sel;
        logic [3:0]   addr;
        logic [127:0] din;
        logic         e_vld;
        logic         e_err;
        logic [127:0] e_data;
    } vec_t;

    function automatic logic [127:0] L(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] typ,
                         input logic [1:0] sel, input logic [3:0] addr,
                         input logic [127:0] din);
        in_req_valid = 1'b1; in_read_en = rd; in_write_en = wr; in_type = typ;
        in_select_matrix = sel; in_address = addr; in_data = din;
    endtask

    task automatic idle();
        in_req_valid = 1'b0; in_read_en = 1'b0; in_write_en = 1'b0;
        in_clear = 1'b0; in_data = '0;
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    // One-cycle request, then check the registered response.
    task automatic req_chk(input string name, input logic rd, input logic wr,
                           input logic [1:0] typ, input logic [1:0] sel,
                           input logic [3:0] addr, input logic [127:0] din,
                           input logic e_vld, input logic e_err, input logic [127:0] e_data);
        drive(rd, wr, typ, sel, addr, din);
        step();
        idle();
        chk({name, ".vld"}, 128'(out_rd_valid), 128'(e_vld));
        chk({name, ".err"}, 128'(out_error), 128'(e_err));
        chk({name, ".data"}, out_data, e_data);
    endtask

    vec_t vecs[15];
    logic [127:0] exp_rw;

    initial begin
        // m0 diag A..D; m1 row1 11..44; m2 cell15 0x55
        vecs[0]  = '{"rd_row_m2",   1, 0, 2'b01, 2'd2, 4'd8,  '0, 1, 0, '0};
        vecs[1]  = '{"wr_row_m1",   0, 1, 2'b01, 2'd1, 4'd4,  L(11, 22, 33, 44), 0, 0, '0};
        vecs[2]  = '{"rd_col_m1",   1, 0, 2'b10, 2'd1, 4'd1,  '0, 1, 0, L(0, 22, 0, 0)};
        vecs[3]  = '{"wr_diag_m0",  0, 1, 2'b11, 2'd0, 4'd0,  L('hA, 'hB, 'hC, 'hD), 0, 0, L(0, 22, 0, 0)};
        vecs[4]  = '{"rd_cell10",   1, 0, 2'b00, 2'd0, 4'd10, '0, 1, 0, L('hC, 0, 0, 0)};
        vecs[5]  = '{"bad_diag",    1, 0, 2'b11, 2'd0, 4'd1,  '0, 0, 1, L('hC, 0, 0, 0)};
        vecs[6]  = '{"bad_sel_wr",  0, 1, 2'b00, 2'd3, 4'd0,  L('h99, 'h99, 'h99, 'h99), 0, 1, L('hC, 0, 0, 0)};
        vecs[7]  = '{"rd_row0_m0",  1, 0, 2'b01, 2'd0, 4'd0,  '0, 1, 0, L('hA, 0, 0, 0)};
        vecs[8]  = '{"rd_row1_m1",  1, 0, 2'b01, 2'd1, 4'd4,  '0, 1, 0, L(11, 22, 33, 44)};
        vecs[9]  = '{"bad_row5",    1, 0, 2'b01, 2'd1, 4'd5,  '0, 0, 1, L(11, 22, 33, 44)};
        vecs[10] = '{"bad_col4",    1, 0, 2'b10, 2'd1, 4'd4,  '0, 0, 1, L(11, 22, 33, 44)};
        vecs[11] = '{"wr_cell15",   0, 1, 2'b00, 2'd2, 4'd15, L('h55, 'h66, 'h77, 'h88), 0, 0, L(11, 22, 33, 44)};
        vecs[12] = '{"rd_row3_m2",  1, 0, 2'b01, 2'd2, 4'd12, '0, 1, 0, L(0, 0, 0, 'h55)};
        vecs[13] = '{"no_enables",  0, 0, 2'b01, 2'd0, 4'd0,  '0, 0, 0, L(0, 0, 0, 'h55)};
        vecs[14] = '{"rd_diag_m0",  1, 0, 2'b11, 2'd0, 4'd0,  '0, 1, 0, L('hA, 'hB, 'hC, 'hD)};

        step(); step();
        chk("reset.data", out_data, '0);
        chk("reset.vld", 128'(out_rd_valid), 128'(0));
        chk("reset.err", 128'(out_error), 128'(0));
        chk("reset.busy", 128'(out_busy), 128'(0));
        in_reset = 1'b1;
        step();
        chk("reset.ready", 128'(out_req_ready), 128'(1));

        // Back-to-back, one request per cycle.
        for (int v = 0; v < 15; v++)
            req_chk(vecs[v].name, vecs[v].rd, vecs[v].wr, vecs[v].typ, vecs[v].sel,
                    vecs[v].addr, vecs[v].din, vecs[v].e_vld, vecs[v].e_err, vecs[v].e_data);

        // Fill m1, then clear it while a request is offered in the same cycle.
        req_chk("fill_r0", 0, 1, 2'b01, 2'd1, 4'd0,  L(1, 2, 3, 4), 0, 0, L('hA, 'hB, 'hC, 'hD));
        req_chk("fill_r2", 0, 1, 2'b01, 2'd1, 4'd8,  L(5, 6, 7, 8), 0, 0, L('hA, 'hB, 'hC, 'hD));
        req_chk("fill_r3", 0, 1, 2'b01, 2'd1, 4'd12, L(9, 9, 9, 9), 0, 0, L('hA, 'hB, 'hC, 'hD));
        drive(1, 0, 2'b01, 2'd1, 4'd0, '0);
        in_clear = 1'b1;
        #1;
        chk("clr.ready_low", 128'(out_req_ready), 128'(0));
        step();
        idle();
        chk("clr.no_rd_vld", 128'(out_rd_valid), 128'(0));
        chk("clr.busy1", 128'(out_busy), 128'(1));
        chk("clr.busy_ready", 128'(out_req_ready), 128'(0));
        for (int k = 2; k <= 4; k++) begin
            step();
            chk($sformatf("clr.busy%0d", k), 128'(out_busy), 128'(1));
        end
        step();
        chk("clr.busy_end", 128'(out_busy), 128'(0));
        chk("clr.ready_back", 128'(out_req_ready), 128'(1));
        for (int r = 0; r < 4; r++)
            req_chk($sformatf("clr.m1_row%0d", r), 1, 0, 2'b01, 2'd1, 4'(r * 4), '0, 1, 0, '0);
        req_chk("clr.m0_diag", 1, 0, 2'b11, 2'd0, 4'd0, '0, 1, 0, L('hA, 'hB, 'hC, 'hD));
        req_chk("clr.m2_row3", 1, 0, 2'b01, 2'd2, 4'd12, '0, 1, 0, L(0, 0, 0, 'h55));

        // Clear with an illegal select: error pulse, no busy.
        in_clear = 1'b1; in_select_matrix = 2'd3;
        step();
        in_clear = 1'b0;
        chk("bad_clr.err", 128'(out_error), 128'(1));
        chk("bad_clr.busy", 128'(out_busy), 128'(0));
        step();
        chk("bad_clr.err_drop", 128'(out_error), 128'(0));

        // Reset during CLEAR aborts it immediately.
        in_clear = 1'b1; in_select_matrix = 2'd2;
        step();
        in_clear = 1'b0;
        step();
        chk("rst_clr.busy_pre", 128'(out_busy), 128'(1));
        in_reset = 1'b0;
        #1;
        chk("rst_clr.busy", 128'(out_busy), 128'(0));
        chk("rst_clr.data", out_data, '0);
        #2 in_reset = 1'b1;
        step();
        chk("rst_clr.idle", 128'(out_busy), 128'(0));
        req_chk("rst_clr.m0_diag", 1, 0, 2'b11, 2'd0, 4'd0, '0, 1, 0, '0);

        // Read+write on the same cell.
        req_chk("rw.init", 0, 1, 2'b00, 2'd0, 4'd5, L(7, 0, 0, 0), 0, 0, '0);
`ifdef MATRIX_RF_BYPASS_EN
        exp_rw = L(9, 0, 0, 0);
`else
        exp_rw = L(7, 0, 0, 0);
`endif
        req_chk("rw.same", 1, 1, 2'b00, 2'd0, 4'd5, L(9, 3, 3, 3), 1, 0, exp_rw);
        req_chk("rw.after", 1, 0, 2'b00, 2'd0, 4'd5, '0, 1, 0, L(9, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_register_bank.md
# matrix_register_bank

Parametrised multi-matrix register store for the coprocessor datapath. It holds NUM_MATRICES square SIZE×SIZE matrices of CELL_WIDTH-bit cells and supports cell, row, column and diagonal reads and writes through one request port, with a registered read response and an error flag for illegal requests. A sequenced whole-matrix clear runs over SIZE cycles. It replaces the fixed three-matrix register file and feeds the multiply/accumulate units.

## Interface
- SIZE, 4, matrix dimension (≥2)
- CELL_WIDTH, 32, bits per cell
- NUM_MATRICES, 3, number of matrices stored (≥1)
- ADDR_WIDTH, $clog2(SIZE*SIZE), cell index width; index = row*SIZE + col
- SEL_WIDTH, $clog2(NUM_MATRICES) (min 1), matrix select width
- in_clk  input  1  clock, all logic on rising edge
- in_reset  input  1  asynchronous, active-low reset
- in_req_valid  input  1  request present this cycle
- out_req_ready  output  1  request accepted when valid&ready; = ~out_busy & ~in_clear
- in_read_en  input  1  request reads
- in_write_en  input  1  request writes
- in_type  input  2  00 cell, 01 row, 10 column, 11 diagonal
- in_select_matrix  input  SEL_WIDTH  target matrix
- in_address  input  ADDR_WIDTH  start cell index
- in_data  input  SIZE*CELL_WIDTH  write lanes, lane i at [i*CELL_WIDTH +: CELL_WIDTH]
- in_clear  input  1  start clearing in_select_matrix
- out_data  output  SIZE*CELL_WIDTH  read lanes, registered
- out_rd_valid  output  1  out_data updated this cycle
- out_error  output  1  previous accepted request was illegal
- out_busy  output  1  clear sequence in progress

## Operation
- Legal addressing: cell, any index < SIZE²; row, index multiple of SIZE (lane i = cell index+i); column, index < SIZE (lane i = index+i*SIZE); diagonal, index must be 0 (lane i = i*(SIZE+1)).
- Illegal: in_select_matrix ≥ NUM_MATRICES, or address breaks the rule for in_type. The request is accepted, nothing is written, out_data is held, and out_error pulses for one cycle.
- Cell read: lane 0 = cell, lanes 1..SIZE-1 = 0. Cell write uses lane 0 only.
- Read and write in the same request: the write commits at the edge. out_data returns pre-write contents (see Configuration).
- Neither enable set but valid: accepted, no effect, no pulses.
- out_data keeps its last read value between reads. It is never driven to Z.
- FSM, two states, IDLE and CLEAR.
  - IDLE to CLEAR on in_clear with a legal select. Latch the matrix and set row counter = 0.
  - CLEAR zeroes row r of the latched matrix each cycle and increments r.
  - CLEAR to IDLE after row SIZE-1 is zeroed.
- in_clear with an illegal select: no clear, out_error pulses next cycle.
- in_clear is ignored while busy.
- in_clear and in_req_valid in the same cycle: the clear wins and the request is not accepted (ready low).

## Timing
- Reset (asynchronous, in_reset=0): every cell = 0, out_data = 0, out_rd_valid = 0, out_error = 0, out_busy = 0, FSM = IDLE. Reset during CLEAR aborts it.
- Read latency is one cycle: a request accepted at edge N gives out_rd_valid=1 and out_data valid after edge N+1… precisely, both are registered at edge N and visible in cycle N+1.
- out_error uses the same timing as out_rd_valid. out_rd_valid=0 whenever out_error=1.
- A write is visible to a read accepted on the next edge.
- Clear: in_clear sampled at edge N. out_busy is high for cycles N+1 through N+SIZE. out_req_ready returns high in cycle N+SIZE+1. Total SIZE cycles, one row per edge.
- Back-to-back requests sustain one per cycle while not busy.

## Configuration
- MATRIX_RF_BYPASS_EN defined: in a read+write request, the lanes returned are the in_data lanes being written. For cell type, lane 0 = in_data lane 0 and the other lanes = 0.
- MATRIX_RF_BYPASS_EN undefined: read+write returns pre-write contents.

## Structure
- matrix_rf_pkg holds:
  - access type encodings (CELL, ROW, COL, DIAG)
  - FSM state enum (IDLE, CLEAR)
  - a lane-index function (type, address, lane, SIZE) returning a cell index
- Sub-module matrix_rf_addr_check is combinational. It takes type, address and select and outputs legal plus per-lane cell indices. It is shared by the read and write paths.

## Test plan
All scenarios use SIZE=4, CELL_WIDTH=32, NUM_MATRICES=3.
- Reset, then a row read of matrix 2 at address 8 -> out_rd_valid=1 the next cycle, out_data=0.
- Row write at address 4 of matrix 1 with lanes 11,22,33,44, then a column read at address 1 -> lane 1 = 22, other lanes 0.
- Diagonal write of A,B,C,D to matrix 0, then a cell read at address 10 -> lane 0 = C, lanes 1..3 = 0. Diagonal read at address 1 -> out_error=1, out_rd_valid=0, out_data unchanged.
- Select 3 with a write -> out_error pulse, contents of all matrices unchanged.
- Fill matrix 1, assert in_clear, and drive in_req_valid in the same cycle -> request not accepted. out_busy high exactly 4 cycles, then row reads of matrix 1 return 0 and matrices 0 and 2 are intact. Reset asserted mid-clear -> out_busy=0 immediately.
- Read+write at cell 5 with old value 7 and new value 9 -> lane 0 = 7 without MATRIX_RF_BYPASS_EN and 9 with it. A subsequent read returns 9 in both builds.
